// File: rtl/game_controller_if.sv
// Signal bundle between game_controller and the button front-end / display logic.
// The controller side uses the slave modport; the front-end/display side uses master.
interface game_controller_if #(
    parameter int N_PLAYERS    = 2,
    parameter int SCORE_W      = 6,
    parameter int GAME_SECONDS = 30
);
    localparam int TIME_W = $clog2(GAME_SECONDS + 1);
    localparam int PID_W  = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

    logic                         start_game;
    logic                         pause;
    logic [N_PLAYERS-1:0]         player_scored;
    logic [2:0]                   state;
    logic                         game_active;
    logic                         sec_tick;
    logic [TIME_W-1:0]            time_left;
    logic [2:0]                   pre_left;
    logic [N_PLAYERS*SCORE_W-1:0] scores;
    logic [PID_W-1:0]             winner;
    logic                         tie;
    logic [SCORE_W-1:0]           high_score;

    modport master (
        output start_game, pause, player_scored,
        input  state, game_active, sec_tick, time_left, pre_left,
        input  scores, winner, tie, high_score
    );

    modport slave (
        input  start_game, pause, player_scored,
        output state, game_active, sec_tick, time_left, pre_left,
        output scores, winner, tie, high_score
    );
endinterface

// File: rtl/game_controller.sv
// Game sequencer: optional countdown, pausable timed round, saturating per-player scores, winner/tie.
// Define HIGH_SCORE_EN to keep a best-score register across games (otherwise high_score is tied to 0).
module game_controller #(
    parameter int N_PLAYERS    = 2,
    parameter int SCORE_W      = 6,
    parameter int GAME_SECONDS = 30,
    parameter int PRE_SECONDS  = 3,
    parameter int TICK_DIV     = 100_000_000
) (
    input  logic             clkIn,
    input  logic             reset,
    game_controller_if.slave bus
);
    localparam int TIME_W  = $clog2(GAME_SECONDS + 1);
    localparam int PID_W   = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0]  TIME_INIT = TIME_W'(GAME_SECONDS);
    localparam logic [2:0]         PRE_INIT  = 3'(PRE_SECONDS);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_RUNNING   = 3'd2,
        S_PAUSED    = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    state_t                            state_q, state_d;
    logic [PRESC_W-1:0]                presc_q, presc_d;
    logic [TIME_W-1:0]                 time_q, time_d;
    logic [2:0]                        pre_q, pre_d;
    logic [N_PLAYERS-1:0][SCORE_W-1:0] scores_q, scores_d, scores_inc;
    logic [PID_W-1:0]                  winner_q, winner_d;
    logic                              tie_q, tie_d;
    logic                              game_active_q, sec_tick_q;

    logic                              tick;
    logic [SCORE_W-1:0]                max_c;
    logic [PID_W-1:0]                  win_c;
    logic                              tie_c;

    assign tick = ((state_q == S_COUNTDOWN) || (state_q == S_RUNNING)) && (presc_q == PRESC_MAX);

    always_comb begin
        scores_inc = scores_q;
        for (int unsigned i = 0; i < N_PLAYERS; i++) begin
            if (bus.player_scored[i] && (scores_q[i] != SCORE_MAX))
                scores_inc[i] = scores_q[i] + SCORE_W'(1);
        end
    end

    // Resolved from the incremented scores so pulses on the final-tick cycle are included.
    always_comb begin
        max_c = scores_inc[0];
        win_c = '0;
        tie_c = 1'b0;
        for (int unsigned i = 1; i < N_PLAYERS; i++) begin
            if (scores_inc[i] > max_c) begin
                max_c = scores_inc[i];
                win_c = PID_W'(i);
                tie_c = 1'b0;
            end else if (scores_inc[i] == max_c) begin
                tie_c = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        time_d   = time_q;
        pre_d    = pre_q;
        scores_d = scores_q;
        winner_d = winner_q;
        tie_d    = tie_q;
        case (state_q)
            S_IDLE, S_FINISH: begin
                presc_d = '0;
                if (bus.start_game) begin
                    scores_d = '0;
                    time_d   = TIME_INIT;
                    winner_d = '0;
                    tie_d    = 1'b0;
                    if (PRE_SECONDS > 0) begin
                        state_d = S_COUNTDOWN;
                        pre_d   = PRE_INIT;
                    end else begin
                        state_d = S_RUNNING;
                    end
                end
            end
            S_COUNTDOWN: begin
                presc_d = tick ? '0 : presc_q + PRESC_W'(1);
                if (tick) begin
                    pre_d = pre_q - 3'd1;
                    if (pre_q == 3'd1)
                        state_d = S_RUNNING;
                end
            end
            S_RUNNING: begin
                presc_d  = tick ? '0 : presc_q + PRESC_W'(1);
                scores_d = scores_inc;
                // The final tick takes priority over a coincident pause.
                if (tick && (time_q == TIME_W'(1))) begin
                    time_d   = '0;
                    state_d  = S_FINISH;
                    winner_d = win_c;
                    tie_d    = tie_c;
                end else begin
                    if (tick)
                        time_d = time_q - TIME_W'(1);
                    if (bus.pause)
                        state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (bus.pause)
                    state_d = S_RUNNING;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            time_q        <= TIME_INIT;
            pre_q         <= '0;
            scores_q      <= '0;
            winner_q      <= '0;
            tie_q         <= 1'b0;
            game_active_q <= 1'b0;
            sec_tick_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            time_q        <= time_d;
            pre_q         <= pre_d;
            scores_q      <= scores_d;
            winner_q      <= winner_d;
            tie_q         <= tie_d;
            game_active_q <= (state_d == S_RUNNING);
            sec_tick_q    <= tick;
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] hs_q, hs_d;

    always_comb begin
        hs_d = hs_q;
        if ((state_q == S_RUNNING) && (state_d == S_FINISH) && (max_c > hs_q))
            hs_d = max_c;
    end

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset)
            hs_q <= '0;
        else
            hs_q <= hs_d;
    end

    assign bus.high_score = hs_q;
`else
    assign bus.high_score = '0;
`endif

    assign bus.state       = state_q;
    assign bus.game_active = game_active_q;
    assign bus.sec_tick    = sec_tick_q;
    assign bus.time_left   = time_q;
    assign bus.pre_left    = pre_q;
    assign bus.scores      = scores_q;
    assign bus.winner      = winner_q;
    assign bus.tie         = tie_q;
endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: per-cycle score/state expectations and per-tick timer expectations.
// Build with or without HIGH_SCORE_EN, matching the RTL build.
module tb_game_controller;
    localparam int NP = 2;
    localparam int SW = 3;
    localparam int GS = 5;
    localparam int PS = 2;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   hs_m = 0;

    typedef struct {
        int         cyc;
        logic [5:0] scores;
        logic [2:0] state;
    } obs_t;

    typedef struct {
        int         cyc;
        logic [2:0] state;
        logic [2:0] tleft;
        logic [2:0] pleft;
    } tick_t;

    obs_t  obs_q[$];
    tick_t tick_q[$];

    game_controller_if #(.N_PLAYERS(NP), .SCORE_W(SW), .GAME_SECONDS(GS)) gc ();

    game_controller #(
        .N_PLAYERS(NP), .SCORE_W(SW), .GAME_SECONDS(GS), .PRE_SECONDS(PS), .TICK_DIV(TD)
    ) dut (
        .clkIn(clk),
        .reset(rst),
        .bus(gc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int hs_exp();
`ifdef HIGH_SCORE_EN
        return hs_m;
`else
        return 0;
`endif
    endfunction

    // Expected state during cycle r of a round whose start pulse is driven at r=0.
    function automatic int st_at(input int r, input int shift);
        if (r <= 0) return 0;
        if (r <= 8) return 1;
        if (shift > 0 && r >= 20 && r <= 30) return 3;
        if (r < 29 + shift) return 2;
        return 4;
    endfunction

    task automatic push_ticks(input int c, input int shift, input bit full);
        tick_q.push_back('{c + 5, 3'd1, 3'd5, 3'd1});
        tick_q.push_back('{c + 9, 3'd2, 3'd5, 3'd0});
        if (full) begin
            for (int k = 1; k <= 5; k++)
                tick_q.push_back('{c + 9 + 4 * k + ((k >= 3) ? shift : 0),
                                   (k == 5) ? 3'd4 : 3'd2, 3'(5 - k), 3'd0});
        end
    endtask

    always @(negedge clk) begin : monitor
        obs_t  o;
        tick_t t;
        if (!rst) begin
            while (obs_q.size() > 0 && obs_q[0].cyc <= cyc) begin
                o = obs_q.pop_front();
                if (o.cyc < cyc) begin
                    check_eq("obs_missed", cyc, o.cyc);
                end else begin
                    check_eq("scores", gc.scores, o.scores);
                    check_eq("state", gc.state, o.state);
                    check_eq("game_active", gc.game_active, (o.state == 3'd2));
                end
            end
            if (gc.sec_tick) begin
                if (tick_q.size() == 0) begin
                    check_eq("tick_extra", 1, 0);
                end else begin
                    t = tick_q.pop_front();
                    check_eq("tick_cycle", cyc, t.cyc);
                    check_eq("tick_state", gc.state, t.state);
                    check_eq("tick_time_left", gc.time_left, t.tleft);
                    check_eq("tick_pre_left", gc.pre_left, t.pleft);
                end
            end else if (tick_q.size() > 0 && tick_q[0].cyc < cyc) begin
                check_eq("tick_missing", cyc, tick_q[0].cyc);
                void'(tick_q.pop_front());
            end
        end
    end

    task automatic play_round(input int n0, input int n1, input bit f0, input bit f1,
                              input bit pp, input bit ign, input int win, input bit tie_e);
        int   c;
        int   shift;
        int   e0;
        int   e1;
        int   mx;
        logic s0;
        logic s1;
        c     = cyc;
        shift = pp ? 11 : 0;
        e0    = 0;
        e1    = 0;
        push_ticks(c, shift, 1'b1);
        for (int r = 0; r <= 30 + shift; r++) begin
            if (r == 29 + shift) begin
                mx = (e0 > e1) ? e0 : e1;
                if (mx > hs_m) hs_m = mx;
                check_eq("winner", gc.winner, win);
                check_eq("tie", gc.tie, tie_e);
                check_eq("time_end", gc.time_left, 0);
                check_eq("high_score", gc.high_score, hs_exp());
            end
            if (st_at(r, shift) == 3)
                check_eq("pause_time", gc.time_left, 3);
            gc.start_game = (r == 0) || (ign && r == 2);
            gc.pause      = (pp && (r == 19 || r == 30)) || (ign && r == 3);
            s0 = (r >= 9 && r < 9 + n0) || (f0 && r == 28 + shift) ||
                 (pp && r >= 21 && r <= 28) || (ign && r == 4);
            s1 = (r >= 9 && r < 9 + n1) || (f1 && r == 28 + shift) ||
                 (pp && r >= 21 && r <= 28) || (ign && r == 4);
            gc.player_scored = {s1, s0};
            if (st_at(r, shift) == 2) begin
                if (s0 && e0 < 7) e0++;
                if (s1 && e1 < 7) e1++;
            end
            obs_q.push_back('{c + r + 1, {3'(e1), 3'(e0)}, 3'(st_at(r + 1, shift))});
            @(negedge clk);
        end
        gc.start_game    = 1'b0;
        gc.pause         = 1'b0;
        gc.player_scored = '0;
    endtask

    task automatic reset_mid_run();
        int c;
        c = cyc;
        push_ticks(c, 0, 1'b0);
        for (int r = 0; r <= 10; r++) begin
            gc.start_game    = (r == 0);
            gc.player_scored = (r == 9 || r == 10) ? 2'b01 : 2'b00;
            @(negedge clk);
        end
        gc.start_game    = 1'b0;
        gc.player_scored = '0;
        check_eq("rst_pre_scores", gc.scores, 6'd2);
        check_eq("rst_pre_state", gc.state, 2);
        rst = 1'b1;
        #1;
        hs_m = 0;
        check_eq("rst_state", gc.state, 0);
        check_eq("rst_scores", gc.scores, 0);
        check_eq("rst_time_left", gc.time_left, 5);
        check_eq("rst_game_active", gc.game_active, 0);
        check_eq("rst_pre_left", gc.pre_left, 0);
        check_eq("rst_high_score", gc.high_score, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        gc.start_game    = 1'b0;
        gc.pause         = 1'b0;
        gc.player_scored = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_state", gc.state, 0);
        check_eq("reset_scores", gc.scores, 0);
        check_eq("reset_time_left", gc.time_left, 5);
        check_eq("reset_pre_left", gc.pre_left, 0);
        check_eq("reset_game_active", gc.game_active, 0);
        check_eq("reset_sec_tick", gc.sec_tick, 0);
        check_eq("reset_winner", gc.winner, 0);
        check_eq("reset_tie", gc.tie, 0);
        check_eq("reset_high_score", gc.high_score, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_hold", gc.state, 0);

        play_round(3, 2, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        play_round(2, 2, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        play_round(5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        play_round(0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        reset_mid_run();
        play_round(9, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);

        @(negedge clk);
        check_eq("obs_queue_empty", obs_q.size(), 0);
        check_eq("tick_queue_empty", tick_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by time %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/game_controller.md
# game_controller

Parametrised game sequencer for the reaction/score game. It runs an optional pre-game countdown, a timed round with pause/resume, and per-player saturating scores, then resolves a winner or tie when time runs out. Seconds are derived internally from clkIn, so no external 1 Hz clock or timer-expired input is needed. Inputs come from the debounced button/sensor front-end; outputs drive the seven-segment/LED display logic.

## Interface
- N_PLAYERS, 2: number of independent score channels (1..8).
- SCORE_W, 6: score width per player; scores saturate at 2^SCORE_W-1.
- GAME_SECONDS, 30: round length in seconds (>=1).
- PRE_SECONDS, 3: pre-game countdown length in seconds (0 = skip countdown).
- TICK_DIV, 100_000_000: clkIn cycles per second.
- Derived widths: TIME_W = $clog2(GAME_SECONDS+1); PID_W = max(1, $clog2(N_PLAYERS)).

Ports (reset is asynchronous, active-high; clock is clkIn):
- clkIn  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_game  in  1  single-cycle pulse, already debounced.
- pause  in  1  single-cycle pulse; toggles pause.
- player_scored  in  N_PLAYERS  bit i: single-cycle score pulse for player i.
- state  out  3  current state encoding.
- game_active  out  1  high only in RUNNING.
- sec_tick  out  1  one-cycle pulse at each second boundary.
- time_left  out  TIME_W  remaining round seconds.
- pre_left  out  3  remaining countdown seconds.
- scores  out  N_PLAYERS*SCORE_W  player i occupies bits [i*SCORE_W +: SCORE_W].
- winner  out  PID_W  winning player index, valid in FINISH.
- tie  out  1  more than one player holds the maximum score, valid in FINISH.
- high_score  out  SCORE_W  best score across games (see Configuration).

## Operation
- States: IDLE=0, COUNTDOWN=1, RUNNING=2, PAUSED=3, FINISH=4. Any other encoding goes to IDLE on the next edge.
- Reset values: state=IDLE; all scores=0; time_left=GAME_SECONDS; pre_left=0; game_active=0; sec_tick=0; winner=0; tie=0; high_score=0; prescaler=0.
- Prescaler: counts 0..TICK_DIV-1 in COUNTDOWN and RUNNING. It holds its value in PAUSED and is cleared in IDLE, in FINISH, and on entry to COUNTDOWN or RUNNING from IDLE/FINISH. A tick occurs on the cycle where the count is TICK_DIV-1.
- IDLE, on start_game:
  - PRE_SECONDS>0: go to COUNTDOWN with pre_left=PRE_SECONDS.
  - PRE_SECONDS=0: go directly to RUNNING.
  - In both cases scores clear and time_left reloads to GAME_SECONDS.
- COUNTDOWN:
  - Each tick decrements pre_left.
  - The tick taken with pre_left==1 enters RUNNING.
  - player_scored, pause and start_game are ignored.
- RUNNING:
  - player_scored[i] increments score i, saturating. Simultaneous pulses on several channels all count.
  - Each tick decrements time_left. The tick taken with time_left==1 sets it to 0 and enters FINISH; score pulses on that same cycle still count.
  - pause enters PAUSED. start_game is ignored.
- PAUSED:
  - Prescaler, time_left and scores are frozen; player_scored is ignored.
  - pause returns to RUNNING. start_game is ignored.
- FINISH:
  - winner is the lowest index holding the maximum final score, including the last-cycle increments.
  - tie=1 if two or more players share that maximum.
  - Scores and time_left=0 hold.
  - start_game behaves exactly as in IDLE: clear scores, reload time_left, start a new game.
- Simultaneous pause and tick in RUNNING: the tick is applied and the state goes to PAUSED.
- Simultaneous pause and final tick: FINISH wins and pause is dropped.

## Timing
- All outputs are registered and reflect a qualifying input on the next rising edge of clkIn. Reset acts immediately and asynchronously.
- start_game pulse to state=COUNTDOWN: 1 cycle.
- Time in COUNTDOWN: exactly PRE_SECONDS*TICK_DIV cycles.
- Time in RUNNING: exactly GAME_SECONDS*TICK_DIV cycles, excluding cycles spent in PAUSED.
- sec_tick is asserted on the cycle after the prescaler reaches TICK_DIV-1, together with the decremented counter value.
- Score latency: a pulse at edge N shows on scores after edge N+1.
- winner and tie are valid in the first FINISH cycle.

## Configuration
- HIGH_SCORE_EN defined:
  - On each entry to FINISH, high_score takes the maximum final score if that maximum is strictly greater than the current high_score.
  - high_score is cleared only by reset and holds across games.
- HIGH_SCORE_EN undefined: the high_score port exists, is tied to 0, and no register is built.

## Test plan
All scenarios use N_PLAYERS=2, SCORE_W=3, GAME_SECONDS=5, PRE_SECONDS=2, TICK_DIV=4.
- Normal round: start_game pulse -> state=1 next cycle; state=2 after 8 cycles; time_left steps 5,4,3,2,1,0 every 4 cycles; state=4 after 20 RUNNING cycles.
- Saturation: 9 pulses on player_scored[0] during RUNNING -> score0=7 and holds; score1=0.
- Final-cycle tie: score0=3, score1=2, then both pulses on the final-tick cycle -> scores 4/3 in FINISH, winner=0, tie=0. With equal scores instead -> tie=1, winner=0.
- Pause: pause at prescaler=2 with time_left=3, wait 10 cycles, pause again -> time_left stays 3 throughout; next tick 2 cycles after resume; pulses during PAUSED ignored.
- Reset mid-RUNNING -> immediately state=0, scores=0, time_left=5, game_active=0; a start pulse and pause pulses in COUNTDOWN are ignored.
- High score (HIGH_SCORE_EN defined): game 1 max=5, then game 2 max=3 -> high_score=5 after both. Same sequence without HIGH_SCORE_EN -> high_score=0.
